lsu: RTL and testbench

- Load/store unit that initiates accesses to the word-addressed data memory from the core's MEM stage.
- Converts byte-addressed RV32I loads and stores (LB/LH/LW/LBU/LHU/SB/SH/SW) into dmem word reads and writes.
- The dmem port has a combinational read, a one-cycle write and no byte enables, so SB/SH are done as two-cycle read-modify-writes.
- Returns aligned, extended load data, or an error for misaligned or illegal requests.

---
 rtl/lsu_pkg.sv | 21 ++
 rtl/lsu_align.sv | 72 +++++++
 rtl/lsu.sv | 123 ++++++++++++
 tb/tb_lsu.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared constants and types for the load/store unit.
//   - RV32I funct3 size/sign codes (stores reuse codes 0/1/2 for SB/SH/SW)
//   - FSM state encoding
//   - default dmem word-address width and the RV32 data width
package lsu_pkg;

  localparam int RV32_DATA_WIDTH = 32;
  localparam int DMEM_AW_DEF     = 10;

  localparam logic [2:0] LSU_LB  = 3'd0;
  localparam logic [2:0] LSU_LH  = 3'd1;
  localparam logic [2:0] LSU_LW  = 3'd2;
  localparam logic [2:0] LSU_LBU = 3'd4;
  localparam logic [2:0] LSU_LHU = 3'd5;

  typedef enum logic {
    LSU_IDLE   = 1'b0,
    LSU_RMW_WR = 1'b1
  } lsu_state_e;

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational datapath for the load/store unit.
//   funct3, we, addr_lo : request size/sign code, store flag, byte offset
//   rd_data             : word read from dmem at the request's word address
//   wdata_lo            : low half of the store data (SB/SH)
//   err                 : misaligned access or unsupported funct3/direction
//   load_data           : extracted lane, sign/zero extended
//   merged              : rd_data with the SB/SH lane replaced by wdata_lo
module lsu_align
  import lsu_pkg::*;
#(
  parameter int XLEN = RV32_DATA_WIDTH
) (
  input  logic [2:0]      funct3,
  input  logic            we,
  input  logic [1:0]      addr_lo,
  input  logic [XLEN-1:0] rd_data,
  input  logic [15:0]     wdata_lo,
  output logic            err,
  output logic [XLEN-1:0] load_data,
  output logic [XLEN-1:0] merged
);

  logic [4:0]      byte_shift;
  logic [4:0]      half_shift;
  logic [7:0]      lane_b;
  logic [15:0]     lane_h;
  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] mask;
  logic [XLEN-1:0] ins;

  assign byte_shift = {addr_lo, 3'b000};
  assign half_shift = {addr_lo[1], 4'b0000};
  assign shifted    = rd_data >> byte_shift;
  assign lane_b     = shifted[7:0];
  assign lane_h     = addr_lo[1] ? rd_data[31:16] : rd_data[15:0];

  always_comb begin
    err = 1'b0;
    case (funct3)
      LSU_LB:           err = 1'b0;
      LSU_LH:           err = addr_lo[0];
      LSU_LW:           err = |addr_lo;
      LSU_LBU:          err = we;
      LSU_LHU:          err = we | addr_lo[0];
      default:          err = 1'b1;
    endcase
  end

  always_comb begin
    load_data = rd_data;
    case (funct3)
      LSU_LB:  load_data = {{(XLEN-8){lane_b[7]}}, lane_b};
      LSU_LH:  load_data = {{(XLEN-16){lane_h[15]}}, lane_h};
      LSU_LBU: load_data = {{(XLEN-8){1'b0}}, lane_b};
      LSU_LHU: load_data = {{(XLEN-16){1'b0}}, lane_h};
      default: load_data = rd_data;
    endcase
  end

  // SH always lands on lane 0 or 2; misaligned SH is flagged by err and never merged.
  always_comb begin
    if (funct3 == LSU_LH) begin
      mask = {{(XLEN-16){1'b0}}, 16'hFFFF} << half_shift;
      ins  = {{(XLEN-16){1'b0}}, wdata_lo} << half_shift;
    end else begin
      mask = {{(XLEN-8){1'b0}}, 8'hFF} << byte_shift;
      ins  = {{(XLEN-8){1'b0}}, wdata_lo[7:0]} << byte_shift;
    end
    merged = (rd_data & ~mask) | ins;
  end

endmodule

// File: rtl/lsu.sv
// lsu: load/store unit between the MEM stage and a word-addressed dmem
// (combinational read, one-cycle write, no byte enables).
//   clk, rst_n                     : clock, async active-low reset
//   i_req_valid/o_req_ready        : request handshake
//   i_req_we/funct3/addr/wdata     : request fields (byte address)
//   o_rsp_valid/o_rsp_data/o_rsp_err : one-cycle response pulse
//   o_dmem_addr/i_dmem_rd_data     : dmem word address and read data
//   o_dmem_wr_en/o_dmem_wr_data    : dmem write strobe and word
// Loads and SW finish in the accept cycle; SB/SH read-modify-write over two.
module lsu
  import lsu_pkg::*;
#(
  parameter int DMEM_AW = DMEM_AW_DEF,
  parameter int XLEN    = RV32_DATA_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_req_valid,
  output logic               o_req_ready,
  input  logic               i_req_we,
  input  logic [2:0]         i_req_funct3,
  input  logic [31:0]        i_req_addr,
  input  logic [XLEN-1:0]    i_req_wdata,
  output logic               o_rsp_valid,
  output logic [XLEN-1:0]    o_rsp_data,
  output logic               o_rsp_err,
  output logic [DMEM_AW-1:0] o_dmem_addr,
  input  logic [XLEN-1:0]    i_dmem_rd_data,
  output logic               o_dmem_wr_en,
  output logic [XLEN-1:0]    o_dmem_wr_data
);

  lsu_state_e        state_q, state_d;
  logic              rsp_valid_d, rsp_err_d;
  logic [XLEN-1:0]   rsp_data_d;
  logic [DMEM_AW-1:0] rmw_addr_q, rmw_addr_d;
  logic [XLEN-1:0]   rmw_data_q, rmw_data_d;
  logic [DMEM_AW-1:0] req_waddr;
  logic              wr_en;
  logic              err;
  logic [XLEN-1:0]   load_data;
  logic [XLEN-1:0]   merged;
  logic              unused_addr_hi;

  // Addresses beyond the dmem range wrap by dropping the upper bits.
  assign req_waddr      = i_req_addr[DMEM_AW+1:2];
  assign unused_addr_hi = ^i_req_addr[31:DMEM_AW+2];

  lsu_align #(.XLEN(XLEN)) u_align (
    .funct3    (i_req_funct3),
    .we        (i_req_we),
    .addr_lo   (i_req_addr[1:0]),
    .rd_data   (i_dmem_rd_data),
    .wdata_lo  (i_req_wdata[15:0]),
    .err       (err),
    .load_data (load_data),
    .merged    (merged)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= LSU_IDLE;
      o_rsp_valid <= 1'b0;
      o_rsp_data  <= '0;
      o_rsp_err   <= 1'b0;
      rmw_addr_q  <= '0;
      rmw_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      o_rsp_valid <= rsp_valid_d;
      o_rsp_data  <= rsp_data_d;
      o_rsp_err   <= rsp_err_d;
      rmw_addr_q  <= rmw_addr_d;
      rmw_data_q  <= rmw_data_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    rsp_valid_d    = 1'b0;
    rsp_data_d     = '0;
    rsp_err_d      = 1'b0;
    rmw_addr_d     = rmw_addr_q;
    rmw_data_d     = rmw_data_q;
    o_req_ready    = 1'b0;
    o_dmem_addr    = req_waddr;
    o_dmem_wr_data = i_req_wdata;
    wr_en          = 1'b0;
    case (state_q)
      LSU_IDLE: begin
        o_req_ready = 1'b1;
        if (i_req_valid) begin
          if (err) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else if (!i_req_we) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = load_data;
          end else if (i_req_funct3 == LSU_LW) begin
            wr_en       = 1'b1;
            rsp_valid_d = 1'b1;
          end else begin
            rmw_addr_d = req_waddr;
            rmw_data_d = merged;
            state_d    = LSU_RMW_WR;
          end
        end
      end
      LSU_RMW_WR: begin
        o_dmem_addr    = rmw_addr_q;
        o_dmem_wr_data = rmw_data_q;
        wr_en          = 1'b1;
        rsp_valid_d    = 1'b1;
        state_d        = LSU_IDLE;
      end
      default: state_d = LSU_IDLE;
    endcase
  end

  // The SW path is combinational from the request, so hold the strobe off during reset too.
  assign o_dmem_wr_en = wr_en & rst_n;

endmodule

// File: tb/tb_lsu.sv
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic [9:0]  dmem_addr;
  logic [31:0] dmem_rd_data;
  logic        dmem_wr_en;
  logic [31:0] dmem_wr_data;

  logic [31:0] mem [0:1023];
  logic [32:0] exp_q [$];
  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;

  always #5 clk = ~clk;

  lsu #(.DMEM_AW(10), .XLEN(32)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_req_valid    (req_valid),
    .o_req_ready    (req_ready),
    .i_req_we       (req_we),
    .i_req_funct3   (req_funct3),
    .i_req_addr     (req_addr),
    .i_req_wdata    (req_wdata),
    .o_rsp_valid    (rsp_valid),
    .o_rsp_data     (rsp_data),
    .o_rsp_err      (rsp_err),
    .o_dmem_addr    (dmem_addr),
    .i_dmem_rd_data (dmem_rd_data),
    .o_dmem_wr_en   (dmem_wr_en),
    .o_dmem_wr_data (dmem_wr_data)
  );

  assign dmem_rd_data = mem[dmem_addr];

  always @(posedge clk) begin
    if (dmem_wr_en) begin
      mem[dmem_addr] <= dmem_wr_data;
      wr_cnt = wr_cnt + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every response pulse pops one expectation.
  always @(negedge clk) begin
    if (rst_n && rsp_valid) begin
      checks = checks + 1;
      if (exp_q.size() == 0) begin
        errors = errors + 1;
        $display("FAIL rsp_unexpected: got data=%h err=%b, no response expected", rsp_data, rsp_err);
      end else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        if ({rsp_err, rsp_data} !== e) begin
          errors = errors + 1;
          $display("FAIL rsp: got err=%b data=%h expected err=%b data=%h",
                   rsp_err, rsp_data, e[32], e[31:0]);
        end
      end
    end
  end

  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] exp_d,
                       input logic exp_e, input bit push);
    int n;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      checks = checks + 1;
      errors = errors + 1;
      $display("FAIL ready_timeout: got ready=0 expected 1");
    end
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    if (push) exp_q.push_back({exp_e, exp_d});
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  int w0;

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    mem[1] = 32'h8899AABB;
    #12;
    chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("reset_rsp_data", rsp_data, 32'd0);
    chk("reset_rsp_err", {31'd0, rsp_err}, 32'd0);
    chk("reset_wr_en", {31'd0, dmem_wr_en}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // back-to-back loads
    issue(1'b0, 3'd0, 32'h5, 32'h0, 32'hFFFFFFAA, 1'b0, 1);
    issue(1'b0, 3'd4, 32'h5, 32'h0, 32'h000000AA, 1'b0, 1);
    issue(1'b0, 3'd1, 32'h6, 32'h0, 32'hFFFF8899, 1'b0, 1);
    issue(1'b0, 3'd5, 32'h6, 32'h0, 32'h00008899, 1'b0, 1);
    issue(1'b0, 3'd2, 32'h4, 32'h0, 32'h8899AABB, 1'b0, 1);
    issue(1'b0, 3'd2, 32'h1004, 32'h0, 32'h8899AABB, 1'b0, 1);
    idle(2);

    // SB read-modify-write
    w0 = wr_cnt;
    issue(1'b1, 3'd0, 32'h7, 32'h12, 32'h0, 1'b0, 1);
    chk("sb_accept_no_write", wr_cnt - w0, 32'd0);
    chk("sb_rmw_ready", {31'd0, req_ready}, 32'd0);
    chk("sb_rmw_wr_en", {31'd0, dmem_wr_en}, 32'd1);
    chk("sb_rmw_addr", {22'd0, dmem_addr}, 32'd1);
    chk("sb_rmw_data", dmem_wr_data, 32'h1299AABB);
    issue(1'b0, 3'd2, 32'h4, 32'h0, 32'h1299AABB, 1'b0, 1);
    chk("sb_write_count", wr_cnt - w0, 32'd1);
    idle(2);

    // SH and SW
    issue(1'b1, 3'd1, 32'h4, 32'hCAFE, 32'h0, 1'b0, 1);
    idle(3);
    chk("sh_mem1", mem[1], 32'h1299CAFE);
    w0 = wr_cnt;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd2;
    req_addr = 32'h8; req_wdata = 32'hDEADBEEF;
    exp_q.push_back({1'b0, 32'h0});
    #1;
    chk("sw_accept_wr_en", {31'd0, dmem_wr_en}, 32'd1);
    chk("sw_accept_data", dmem_wr_data, 32'hDEADBEEF);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    idle(2);
    chk("sw_mem2", mem[2], 32'hDEADBEEF);
    chk("sw_write_count", wr_cnt - w0, 32'd1);

    // error requests: no writes allowed
    w0 = wr_cnt;
    issue(1'b0, 3'd2, 32'h6, 32'h0, 32'h0, 1'b1, 1);
    issue(1'b1, 3'd1, 32'h5, 32'hBEEF, 32'h0, 1'b1, 1);
    issue(1'b0, 3'd3, 32'h4, 32'h0, 32'h0, 1'b1, 1);
    issue(1'b1, 3'd4, 32'h4, 32'h77, 32'h0, 1'b1, 1);
    issue(1'b1, 3'd2, 32'h9, 32'h11223344, 32'h0, 1'b1, 1);
    idle(3);
    chk("err_write_count", wr_cnt - w0, 32'd0);
    chk("err_mem1", mem[1], 32'h1299CAFE);
    chk("err_mem2", mem[2], 32'hDEADBEEF);

    // reset during RMW_WR abandons the write
    w0 = wr_cnt;
    issue(1'b1, 3'd0, 32'h4, 32'h55, 32'h0, 1'b0, 0);
    rst_n = 1'b0;
    #1;
    chk("rst_rmw_wr_en", {31'd0, dmem_wr_en}, 32'd0);
    chk("rst_rmw_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rmw_rsp_data", rsp_data, 32'd0);
    chk("rst_rmw_rsp_err", {31'd0, rsp_err}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_no_write", wr_cnt - w0, 32'd0);
    chk("rst_mem1", mem[1], 32'h1299CAFE);
    issue(1'b0, 3'd2, 32'h4, 32'h0, 32'h1299CAFE, 1'b0, 1);
    idle(3);

    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
